// File: rtl/add32_pkg.sv
// add32_pkg: shared sizing for the 32-bit carry-lookahead adder.
//   ADD32_WIDTH : default operand width
//   ADD32_BLK   : default lookahead group width
//   NGRP        : number of lookahead groups at the default sizing
package add32_pkg;

  localparam int ADD32_WIDTH = 32;
  localparam int ADD32_BLK   = 4;
  localparam int NGRP        = ADD32_WIDTH / ADD32_BLK;

endpackage : add32_pkg

// File: rtl/add32_cla4.sv
// cla4: one BLK-bit carry-lookahead group.
// Ports:
//   a, b  : group operand slices
//   cin   : carry into the group
//   sum   : group sum bits
//   G, P  : group generate / propagate, independent of cin
module cla4
  import add32_pkg::*;
#(
  parameter int BLK = ADD32_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           G,
  output logic           P
);

  logic [BLK-1:0] g;
  logic [BLK-1:0] p;
  logic [BLK-1:0] c;
  logic           gg;

  assign g = a & b;
  assign p = a ^ b;
  assign P = &p;

  // G and P are kept in a process that never reads cin, so the group
  // lookahead above this module has no path back through the carries.
  always_comb begin
    gg = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      gg = g[i] | (p[i] & gg);
    end
    G = gg;
  end

  // Intra-group carries; the loop unrolls into flat sum-of-products terms
  // of g, p and cin for a small group.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < BLK; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum = p ^ c;
  end

endmodule : cla4

// File: rtl/add32.sv
// add32: two-level carry-lookahead adder with a registered result stage.
// Ports:
//   CLK      : rising-edge clock for the registered outputs
//   RSTb     : synchronous, active-high reset of the registered outputs
//   i_a, i_b : operands (unsigned or two's complement)
//   i_c      : carry-in
//   o_sum    : combinational sum of i_a + i_b + i_c
//   o_c      : combinational carry-out
//   o_sum_q  : o_sum registered
//   o_c_q    : o_c registered
//   o_ovf_q  : registered signed-overflow flag
//   o_zero_q : registered flag, high when the registered sum is zero
module add32
  import add32_pkg::*;
#(
  parameter int WIDTH = ADD32_WIDTH,
  parameter int BLK   = ADD32_BLK
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c,
  output logic [WIDTH-1:0] o_sum_q,
  output logic             o_c_q,
  output logic             o_ovf_q,
  output logic             o_zero_q
);

  localparam int NG = WIDTH / BLK;

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;
  logic          ovf;
  logic          zero;

  // Signed overflow: like-signed operands producing a differently signed sum.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Stage 0: per-group lookahead blocks.
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4 #(
      .BLK (BLK)
    ) u_cla (
      .a   (i_a[k*BLK +: BLK]),
      .b   (i_b[k*BLK +: BLK]),
      .cin (grp_c[k]),
      .sum (o_sum[k*BLK +: BLK]),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
  end

  // Second lookahead level: group carry-ins from the carry-in and group G/P.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = i_c;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  assign o_c  = grp_c[NG];
  assign ovf  = signed_ovf(i_a[WIDTH-1], i_b[WIDTH-1], o_sum[WIDTH-1]);
  assign zero = (o_sum == '0);

  // Stage 1: registered result; reset wins over capture.
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      o_sum_q  <= '0;
      o_c_q    <= 1'b0;
      o_ovf_q  <= 1'b0;
      o_zero_q <= 1'b0;
    end else begin
      o_sum_q  <= o_sum;
      o_c_q    <= o_c;
      o_ovf_q  <= ovf;
      o_zero_q <= zero;
    end
  end

endmodule : add32

// File: tb/tb_add32.sv
// tb_add32: scoreboard bench for add32. The driver checks the combinational
// outputs 0.1 period after each input change and queues the registered
// response expected after the next rising edge; a monitor pops and compares.
module tb_add32;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b1;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_c = 1'b0;
  logic [31:0] o_sum;
  logic        o_c;
  logic [31:0] o_sum_q;
  logic        o_c_q;
  logic        o_ovf_q;
  logic        o_zero_q;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  add32 dut (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_c      (i_c),
    .o_sum    (o_sum),
    .o_c      (o_c),
    .o_sum_q  (o_sum_q),
    .o_c_q    (o_c_q),
    .o_ovf_q  (o_ovf_q),
    .o_zero_q (o_zero_q)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one vector at the falling edge, check the combinational result
  // 2 ns later, and queue the registered response for the next edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic rst, input logic [31:0] e_sum, input logic e_c,
                       input logic e_ovf);
    exp_t e;
    @(negedge CLK);
    i_a  = a;
    i_b  = b;
    i_c  = c;
    RSTb = rst;
    #2;
    chk("o_sum", o_sum, e_sum);
    chk("o_c", {31'd0, o_c}, {31'd0, e_c});
    if (rst) begin
      e.sum = '0; e.c = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
    end else begin
      e.sum = e_sum; e.c = e_c; e.ovf = e_ovf; e.zero = (e_sum == 32'd0);
    end
    sb_q.push_back(e);
  endtask

  task automatic apply_golden(input logic [31:0] a, input logic [31:0] b,
                              input logic c, input logic rst);
    logic [32:0] s;
    logic        v;
    s = {1'b0, a} + {1'b0, b} + {32'd0, c};
    v = (a[31] == b[31]) && (s[31] != a[31]);
    apply(a, b, c, rst, s[31:0], s[32], v);
  endtask

  // Monitor: every rising edge retires one queued expectation.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("o_sum_q", o_sum_q, e.sum);
      chk("o_c_q", {31'd0, o_c_q}, {31'd0, e.c});
      chk("o_ovf_q", {31'd0, o_ovf_q}, {31'd0, e.ovf});
      chk("o_zero_q", {31'd0, o_zero_q}, {31'd0, e.zero});
    end
  end

  initial begin
    int wait_cyc;
    // Reset cycle: registered outputs must read zero, comb path still valid.
    apply(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    // Directed vectors, hand-computed.
    apply(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    apply(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1);
    apply(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    apply(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    apply(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    // Random vectors against the 33-bit golden sum.
    for (int n = 0; n < 50; n++) begin
      apply_golden($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    // Mid-stream reset with nonzero inputs.
    apply(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b1, 32'hEFBE_D001, 1'b0, 1'b0);
    for (int n = 0; n < 50; n++) begin
      apply_golden($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    // Drain the scoreboard with a bounded wait.
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge CLK);
      #2;
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_add32
